gen1_scrambler_pipe: RTL and testbench

- Sequential Gen1 (2.5 GT/s) per-lane transmit scrambler stage.
- Sits between the lane symbol mux (upstream) and the 8b/10b encoder (downstream).
- Owns the 16-bit scrambler LFSR register (G(X)=X^16+X^5+X^4+X^3+1, advanced 8 bits per symbol) and XORs it into data symbols.
- Applies the Gen1 bypass rules for K-symbols, SKP, COM and TS1/TS2 ordered sets, with a 1-deep valid/ready output register.

---
 rtl/gen1_scrambler_pipe.sv | 152 +++++++++++++++
 tb/tb_gen1_scrambler_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/gen1_scrambler_pipe.sv
// Purpose : Gen1 per-lane transmit scrambler stage between the lane symbol mux and the 8b/10b encoder.
// Latency : 1 cycle from accept to out_valid_o; LFSR and ordered-set tracking advance on accept only.
// Backprsr: 1-deep output register; in_ready_o = ~out_valid_o | out_ready_i, everything frozen while stalled.
//
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   scramble_enable_i                  1 = scramble data symbols, 0 = pass-through with LFSR frozen
//   in_valid_i/in_ready_o/in_data_i/in_k_i      upstream symbol handshake
//   out_valid_o/out_ready_i/out_data_o/out_k_o  downstream symbol handshake
module gen1_scrambler_pipe #(
   parameter int          TS_LEN    = 16,
   parameter logic [15:0] LFSR_SEED = 16'hFFFF
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       scramble_enable_i,
   input  logic       in_valid_i,
   output logic       in_ready_o,
   input  logic [7:0] in_data_i,
   input  logic       in_k_i,
   output logic       out_valid_o,
   input  logic       out_ready_i,
   output logic [7:0] out_data_o,
   output logic       out_k_o
);

   localparam int CW = $clog2(TS_LEN);

   localparam logic [7:0] SYM_COM = 8'hBC;
   localparam logic [7:0] SYM_SKP = 8'h1C;
   localparam logic [7:0] SYM_PAD = 8'hF7;

   typedef enum logic [1:0] {
      ST_DATA,
      ST_OS_ID,
      ST_TS_BODY
   } state_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  ts_cnt, ts_cnt_nxt;
   logic [15:0]    lfsr, lfsr_nxt;
   logic [7:0]     scr_byte;
   logic [7:0]     data_nxt;
   logic           accept;
   logic           is_com, is_skp, is_pad;
   logic           ts_sym;
   logic           do_scramble;

   // Eight serial shifts of the Galois LFSR (taps x^5, x^4, x^3, 1) collapsed into one step.
   function automatic logic [15:0] lfsr_step8(input logic [15:0] o);
      logic [15:0] n;
      n[0]  = o[8];
      n[1]  = o[9];
      n[2]  = o[10];
      n[3]  = o[8]  ^ o[11];
      n[4]  = o[8]  ^ o[9]  ^ o[12];
      n[5]  = o[8]  ^ o[9]  ^ o[10] ^ o[13];
      n[6]  = o[9]  ^ o[10] ^ o[11] ^ o[14];
      n[7]  = o[10] ^ o[11] ^ o[12] ^ o[15];
      n[8]  = o[0]  ^ o[11] ^ o[12] ^ o[13];
      n[9]  = o[1]  ^ o[12] ^ o[13] ^ o[14];
      n[10] = o[2]  ^ o[13] ^ o[14] ^ o[15];
      n[11] = o[3]  ^ o[14] ^ o[15];
      n[12] = o[4]  ^ o[15];
      n[13] = o[5];
      n[14] = o[6];
      n[15] = o[7];
      return n;
   endfunction

   assign in_ready_o = ~out_valid_o | out_ready_i;
   assign accept     = in_valid_i & in_ready_o;

   assign is_com = in_k_i & (in_data_i == SYM_COM);
   assign is_skp = in_k_i & (in_data_i == SYM_SKP);
   assign is_pad = in_k_i & (in_data_i == SYM_PAD);

   // lfsr[15] is the first scrambling bit out, so it lands on bit 0 of the byte.
   assign scr_byte = {lfsr[8], lfsr[9], lfsr[10], lfsr[11],
                      lfsr[12], lfsr[13], lfsr[14], lfsr[15]};

   always_comb begin
      state_nxt   = state;
      ts_cnt_nxt  = ts_cnt;
      lfsr_nxt    = lfsr;
      ts_sym      = 1'b0;
      do_scramble = 1'b0;
      data_nxt    = in_data_i;

      // Ordered-set tracking runs regardless of scramble_enable_i.
      unique case (state)
         ST_DATA: begin
            if (is_com) state_nxt = ST_OS_ID;
         end
         ST_OS_ID: begin
            if (is_com) begin
               state_nxt = ST_OS_ID;
            end else if (!in_k_i || is_pad) begin
               // First TS symbol after COM already counts as body.
               state_nxt  = ST_TS_BODY;
               ts_cnt_nxt = CW'(TS_LEN - 3);
               ts_sym     = 1'b1;
            end else begin
               state_nxt = ST_DATA;
            end
         end
         ST_TS_BODY: begin
            ts_sym = 1'b1;
            if (is_com) begin
               state_nxt = ST_OS_ID;
            end else if (ts_cnt == '0) begin
               state_nxt = ST_DATA;
            end else begin
               ts_cnt_nxt = ts_cnt - 1'b1;
            end
         end
         default: state_nxt = ST_DATA;
      endcase

      if (is_com) begin
         lfsr_nxt = LFSR_SEED;
      end else if (is_skp || !scramble_enable_i) begin
         lfsr_nxt = lfsr;
      end else begin
         lfsr_nxt = lfsr_step8(lfsr);
      end

      do_scramble = !in_k_i && scramble_enable_i && !ts_sym;
      if (do_scramble) data_nxt = in_data_i ^ scr_byte;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= ST_DATA;
         ts_cnt      <= '0;
         lfsr        <= LFSR_SEED;
         out_valid_o <= 1'b0;
         out_data_o  <= 8'h00;
         out_k_o     <= 1'b0;
      end else if (accept) begin
         state       <= state_nxt;
         ts_cnt      <= ts_cnt_nxt;
         lfsr        <= lfsr_nxt;
         out_valid_o <= 1'b1;
         out_data_o  <= data_nxt;
         out_k_o     <= in_k_i;
      end else if (out_ready_i) begin
         out_valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_gen1_scrambler_pipe.sv
module tb_gen1_scrambler_pipe;

   localparam int          TS_LEN = 16;
   localparam logic [15:0] SEED   = 16'hFFFF;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       scramble_enable_i;
   logic       in_valid_i;
   logic       in_ready_o;
   logic [7:0] in_data_i;
   logic       in_k_i;
   logic       out_valid_o;
   logic       out_ready_i;
   logic [7:0] out_data_o;
   logic       out_k_o;

   gen1_scrambler_pipe #(.TS_LEN(TS_LEN), .LFSR_SEED(SEED)) dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .scramble_enable_i (scramble_enable_i),
      .in_valid_i        (in_valid_i),
      .in_ready_o        (in_ready_o),
      .in_data_i         (in_data_i),
      .in_k_i            (in_k_i),
      .out_valid_o       (out_valid_o),
      .out_ready_i       (out_ready_i),
      .out_data_o        (out_data_o),
      .out_k_o           (out_k_o)
   );

   always #5 clk_i = ~clk_i;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: serial bit-by-bit scrambler plus a position counter inside the ordered set.
   logic [15:0] m_lfsr;
   logic        m_after_com;
   int          m_body_left;
   logic        m_valid;
   logic [8:0]  exp_q[$];
   logic [7:0]  cap_q[$];

   task automatic model_reset();
      m_lfsr      = SEED;
      m_after_com = 1'b0;
      m_body_left = 0;
      m_valid     = 1'b0;
      exp_q.delete();
   endtask

   task automatic model_sym(input logic [7:0] d, input logic k, input logic en, output logic [8:0] res);
      logic       body;
      logic [7:0] s;
      logic       fb;
      body = 1'b0;
      s    = 8'h00;
      if (k && d == 8'hBC) begin
         m_lfsr      = SEED;
         m_after_com = 1'b1;
         m_body_left = 0;
         res         = {1'b1, d};
         return;
      end
      if (m_after_com) begin
         m_after_com = 1'b0;
         if (!k || d == 8'hF7) begin
            body        = 1'b1;
            m_body_left = TS_LEN - 2;
         end
      end else if (m_body_left > 0) begin
         body = 1'b1;
         m_body_left--;
      end
      if (!(k && d == 8'h1C) && en) begin
         for (int i = 0; i < 8; i++) begin
            fb     = m_lfsr[15];
            s[i]   = fb;
            m_lfsr = {m_lfsr[14:0], 1'b0};
            if (fb) m_lfsr = m_lfsr ^ 16'h0039;
         end
      end
      res = (!k && en && !body) ? {1'b0, d ^ s} : {k, d};
   endtask

   task automatic cycle(input logic v, input logic [7:0] d, input logic k, input logic en, input logic rdy);
      logic       acc;
      logic [8:0] r;
      @(negedge clk_i);
      in_valid_i        = v;
      in_data_i         = d;
      in_k_i            = k;
      scramble_enable_i = en;
      out_ready_i       = rdy;
      #1;
      chk("in_ready", {15'd0, in_ready_o}, {15'd0, ~m_valid | rdy});
      chk("out_valid", {15'd0, out_valid_o}, {15'd0, m_valid});
      if (m_valid && exp_q.size() > 0) begin
         chk("out_sym", {7'd0, out_k_o, out_data_o}, {7'd0, exp_q[0]});
      end
      acc = v & (~m_valid | rdy);
      if (m_valid && rdy) begin
         cap_q.push_back(out_data_o);
         if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (acc) begin
         model_sym(d, k, en, r);
         exp_q.push_back(r);
      end
      m_valid = acc | (m_valid & ~rdy);
   endtask

   task automatic send(input logic [7:0] d, input logic k, input logic en);
      cycle(1'b1, d, k, en, 1'b1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_i       = 1'b1;
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
      model_reset();
      @(negedge clk_i);
      chk("rst_valid", {15'd0, out_valid_o}, 16'd0);
      chk("rst_data",  {8'd0, out_data_o},   16'd0);
      chk("rst_k",     {15'd0, out_k_o},     16'd0);
      rst_i = 1'b0;
   endtask

   logic [7:0] seq_tbl[8];
   logic [7:0] ksyms[6];

   initial begin
      rst_i = 1'b1;
      scramble_enable_i = 1'b1;
      in_valid_i = 1'b0;
      in_data_i = 8'h00;
      in_k_i = 1'b0;
      out_ready_i = 1'b1;
      seq_tbl = '{8'hFF, 8'h17, 8'hC0, 8'h14, 8'hB2, 8'hE7, 8'h02, 8'h82};
      ksyms   = '{8'hBC, 8'h1C, 8'hF7, 8'h3C, 8'h7C, 8'hFC};

      do_reset();

      // Known scrambler byte sequence from the seed, data state.
      cap_q.delete();
      for (int i = 0; i < 8; i++) send(8'h00, 1'b0, 1'b1);
      idle(2);
      chk("seq_n", 16'(cap_q.size()), 16'd8);
      for (int i = 0; i < 8 && i < cap_q.size(); i++) chk("seq_byte", {8'd0, cap_q[i]}, {8'd0, seq_tbl[i]});

      // COM, D, SKP, D.
      send(8'hBC, 1'b1, 1'b1);
      send(8'h00, 1'b0, 1'b1);
      send(8'h1C, 1'b1, 1'b1);
      send(8'h00, 1'b0, 1'b1);
      idle(2);

      // Scrambling disabled, then re-enabled.
      send(8'hBC, 1'b1, 1'b0);
      send(8'h00, 1'b0, 1'b0);
      send(8'h00, 1'b0, 1'b0);
      send(8'h00, 1'b0, 1'b1);
      idle(2);

      // Full TS1: body goes out untouched, then data resumes.
      do_reset();
      cap_q.delete();
      send(8'hBC, 1'b1, 1'b1);
      for (int i = 1; i <= TS_LEN - 1; i++) send(8'(i), 1'b0, 1'b1);
      send(8'h00, 1'b0, 1'b1);
      send(8'h00, 1'b0, 1'b1);
      idle(2);
      chk("ts_n", 16'(cap_q.size()), 16'(TS_LEN + 2));
      for (int i = 1; i <= TS_LEN - 1 && i < cap_q.size(); i++) chk("ts_body", {8'd0, cap_q[i]}, 16'(i));

      // Stall with input pending.
      cap_q.delete();
      send(8'h11, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
      send(8'h22, 1'b0, 1'b1);
      send(8'h33, 1'b0, 1'b1);
      idle(2);
      chk("stall_n", 16'(cap_q.size()), 16'd3);

      // Reset in the middle of an ordered set with a symbol held.
      send(8'hBC, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) send(8'h4A, 1'b0, 1'b1);
      do_reset();
      cap_q.delete();
      send(8'h00, 1'b0, 1'b1);
      idle(1);
      chk("post_rst_n", 16'(cap_q.size()), 16'd1);
      if (cap_q.size() > 0) chk("post_rst_ff", {8'd0, cap_q[0]}, 16'h00FF);

      // Random traffic against the model.
      for (int n = 0; n < 4000; n++) begin
         logic [7:0] d;
         logic       k;
         if ($urandom_range(0, 299) == 0) do_reset();
         k = ($urandom_range(0, 3) == 0);
         d = k ? ksyms[$urandom_range(0, 5)] : 8'($urandom);
         cycle($urandom_range(0, 3) != 0, d, k, $urandom_range(0, 5) != 0, $urandom_range(0, 3) != 0);
      end
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
